// File: rtl/dual_port_ram_bwe_if.sv
// Bus bundle for dual_port_ram_bwe: request and response signals of ports A and B
// plus the shared write/write collision flag.
interface dual_port_ram_bwe_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  a_en;
  logic                  a_we;
  logic [NB-1:0]         a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;
  logic                  a_err;

  logic                  b_en;
  logic                  b_we;
  logic [NB-1:0]         b_be;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;
  logic                  b_err;

  logic                  collision;

  modport master (
    output a_en, a_we, a_be, a_addr, a_wdata,
    output b_en, b_we, b_be, b_addr, b_wdata,
    input  a_rdata, a_rvalid, a_err,
    input  b_rdata, b_rvalid, b_err,
    input  collision
  );

  modport slave (
    input  a_en, a_we, a_be, a_addr, a_wdata,
    input  b_en, b_we, b_be, b_addr, b_wdata,
    output a_rdata, a_rvalid, a_err,
    output b_rdata, b_rvalid, b_err,
    output collision
  );
endinterface

// File: rtl/dual_port_ram_bwe.sv
// True dual-port synchronous RAM with byte write enables, a 1..3 cycle read
// pipeline with rvalid strobes, selectable same-port read-during-write data and
// a write/write collision policy where port A wins overlapping bytes.
module dual_port_ram_bwe #(
  parameter int    ADDR_WIDTH   = 8,
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 1 << ADDR_WIDTH,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    READ_LATENCY = 1,
  parameter string RW_MODE      = "READ_FIRST"
) (
  input  logic                clk,
  input  logic                rst_n,
  dual_port_ram_bwe_if.slave  bus
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam bit WRITE_FIRST = (RW_MODE == "WRITE_FIRST");
  // One extra bit so the range compare stays meaningful when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
    logic                  coll;
  } stage_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_oob, b_oob;
  logic                  a_wr, b_wr;
  logic                  coll_hit;
  logic [DATA_WIDTH-1:0] a_old, b_old;
  stage_t                a_in, b_in;
  stage_t                a_pipe [READ_LATENCY];
  stage_t                b_pipe [READ_LATENCY];

  // Overlay the enabled bytes of new_word onto old_word.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  // Advance one extra pipeline stage; data is held while no pulse passes through.
  function automatic stage_t advance(input stage_t prev, input stage_t cur);
    stage_t r;
    r = prev;
    if (!prev.valid) r.data = cur.data;
    return r;
  endfunction

  // Decode range, write strobes, overlap and the pre-write array contents.
  always_comb begin
    a_oob    = ({1'b0, bus.a_addr} >= DEPTH_L);
    b_oob    = ({1'b0, bus.b_addr} >= DEPTH_L);
    a_wr     = bus.a_en && bus.a_we && !a_oob;
    b_wr     = bus.b_en && bus.b_we && !b_oob;
    coll_hit = a_wr && b_wr && (bus.a_addr == bus.b_addr) && (|(bus.a_be & bus.b_be));
    a_old    = a_oob ? '0 : mem[bus.a_addr];
    b_old    = b_oob ? '0 : mem[bus.b_addr];
  end

  // Build the stage-0 load value for each port from the accepted access.
  always_comb begin
    // NOTE: every field gets a value before any condition, so no latch is inferred.
    a_in       = a_pipe[0];
    a_in.valid = bus.a_en;
    a_in.err   = bus.a_en && a_oob;
    a_in.coll  = coll_hit;
    if (bus.a_en) begin
      if (a_oob)                       a_in.data = '0;
      else if (WRITE_FIRST && bus.a_we) a_in.data = merge(a_old, bus.a_wdata, bus.a_be);
      else                              a_in.data = a_old;
    end

    b_in       = b_pipe[0];
    b_in.valid = bus.b_en;
    b_in.err   = bus.b_en && b_oob;
    b_in.coll  = coll_hit;
    if (bus.b_en) begin
      if (b_oob)                       b_in.data = '0;
      else if (WRITE_FIRST && bus.b_we) b_in.data = merge(b_old, bus.b_wdata, bus.b_be);
      else                              b_in.data = b_old;
    end
  end

  // Byte-lane array writes; A is applied after B so A owns overlapping bytes.
  // NOTE: the array has no reset; it maps onto block RAM and keeps its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b_wr && bus.b_be[i])
        mem[bus.b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    for (int i = 0; i < NB; i++) begin
      if (a_wr && bus.a_be[i])
        mem[bus.a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Read pipeline: stage 0 is the array read register, later stages are plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates let every stage sample its predecessor's old value.
      a_pipe[0] <= a_in;
      b_pipe[0] <= b_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        a_pipe[i] <= advance(a_pipe[i-1], a_pipe[i]);
        b_pipe[i] <= advance(b_pipe[i-1], b_pipe[i]);
      end
    end
  end

  assign bus.a_rdata   = a_pipe[READ_LATENCY-1].data;
  assign bus.a_rvalid  = a_pipe[READ_LATENCY-1].valid;
  assign bus.a_err     = a_pipe[READ_LATENCY-1].err;
  assign bus.b_rdata   = b_pipe[READ_LATENCY-1].data;
  assign bus.b_rvalid  = b_pipe[READ_LATENCY-1].valid;
  assign bus.b_err     = b_pipe[READ_LATENCY-1].err;
  assign bus.collision = a_pipe[READ_LATENCY-1].coll | b_pipe[READ_LATENCY-1].coll;

endmodule

// File: tb/tb_dual_port_ram_bwe.sv
// Directed bench for dual_port_ram_bwe: a READ_FIRST and a WRITE_FIRST instance
// (DEPTH=200, latency 1) share one vector table; a latency-3 instance covers the
// mid-operation reset sequence.
module tb_dual_port_ram_bwe;

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    string       name;
    op_t         a;
    op_t         b;
    logic        xav;
    logic [31:0] xad;
    logic        xae;
    logic        xbv;
    logic [31:0] xbd;
    logic        xbe;
    logic        xcoll;
    logic [31:0] xawf;
    logic [31:0] xbwf;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];
  logic [7:0] init_addrs [5] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd199};

  always #5 clk = ~clk;

  dual_port_ram_bwe_if if_rf ();
  dual_port_ram_bwe_if if_wf ();
  dual_port_ram_bwe_if if_l3 ();

  dual_port_ram_bwe #(.DEPTH(200)) u_rf (.clk(clk), .rst_n(rst_n), .bus(if_rf));
  dual_port_ram_bwe #(.DEPTH(200), .RW_MODE("WRITE_FIRST")) u_wf (.clk(clk), .rst_n(rst_n), .bus(if_wf));
  dual_port_ram_bwe #(.READ_LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst2_n), .bus(if_l3));

  function automatic op_t idle();
    op_t o;
    o.en = 1'b0; o.we = 1'b0; o.be = 4'h0; o.addr = 8'h0; o.wdata = 32'h0;
    return o;
  endfunction

  function automatic op_t rd(input logic [7:0] addr);
    op_t o;
    o = idle();
    o.en = 1'b1; o.addr = addr;
    return o;
  endfunction

  function automatic op_t wr(input logic [7:0] addr, input logic [3:0] be, input logic [31:0] data);
    op_t o;
    o.en = 1'b1; o.we = 1'b1; o.be = be; o.addr = addr; o.wdata = data;
    return o;
  endfunction

  task automatic add(input string name, input op_t a, input op_t b,
                     input logic xav, input logic [31:0] xad, input logic xae,
                     input logic xbv, input logic [31:0] xbd, input logic xbe,
                     input logic xcoll, input logic [31:0] xawf, input logic [31:0] xbwf);
    vec_t v;
    v.name = name; v.a = a; v.b = b;
    v.xav = xav; v.xad = xad; v.xae = xae;
    v.xbv = xbv; v.xbd = xbd; v.xbe = xbe;
    v.xcoll = xcoll; v.xawf = xawf; v.xbwf = xbwf;
    vecs.push_back(v);
  endtask

  task automatic drive(input op_t a, input op_t b);
    if_rf.a_en = a.en; if_rf.a_we = a.we; if_rf.a_be = a.be; if_rf.a_addr = a.addr; if_rf.a_wdata = a.wdata;
    if_rf.b_en = b.en; if_rf.b_we = b.we; if_rf.b_be = b.be; if_rf.b_addr = b.addr; if_rf.b_wdata = b.wdata;
    if_wf.a_en = a.en; if_wf.a_we = a.we; if_wf.a_be = a.be; if_wf.a_addr = a.addr; if_wf.a_wdata = a.wdata;
    if_wf.b_en = b.en; if_wf.b_we = b.we; if_wf.b_be = b.be; if_wf.b_addr = b.addr; if_wf.b_wdata = b.wdata;
  endtask

  task automatic drive_l3(input op_t a);
    if_l3.a_en = a.en; if_l3.a_we = a.we; if_l3.a_be = a.be; if_l3.a_addr = a.addr; if_l3.a_wdata = a.wdata;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- vector table: {stimulus A, stimulus B, expected outputs one cycle later} ----
    //   name            A                             B                          av ad            ae  bv bd            be  coll awf           bwf
    add("t1_wr",       wr(5, 4'hF, 32'hDEADBEEF), idle(),                    1, 32'h00000000, 0, 0, 32'h00000000, 0, 0, 32'hDEADBEEF, 32'h00000000);
    add("t1_rd",       idle(),                    rd(5),                     0, 32'h00000000, 0, 1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    add("t2_init",     wr(7, 4'hF, 32'h11223344), idle(),                    1, 32'h00000000, 0, 0, 32'hDEADBEEF, 0, 0, 32'h11223344, 32'hDEADBEEF);
    add("t2_merge",    wr(7, 4'h5, 32'hAABBCCDD), idle(),                    1, 32'h11223344, 0, 0, 32'hDEADBEEF, 0, 0, 32'h11BB33DD, 32'hDEADBEEF);
    add("t2_rd",       idle(),                    rd(7),                     0, 32'h11223344, 0, 1, 32'h11BB33DD, 0, 0, 32'h11BB33DD, 32'h11BB33DD);
    add("be0",         wr(7, 4'h0, 32'hFFFFFFFF), idle(),                    1, 32'h11BB33DD, 0, 0, 32'h11BB33DD, 0, 0, 32'h11BB33DD, 32'h11BB33DD);
    add("t3_coll",     wr(9, 4'h3, 32'hAAAAAAAA), wr(9, 4'h6, 32'hBBBBBBBB), 1, 32'h00000000, 0, 1, 32'h00000000, 0, 1, 32'h0000AAAA, 32'h00BBBB00);
    add("t3_rd",       rd(9),                     idle(),                    1, 32'h00BBAAAA, 0, 0, 32'h00000000, 0, 0, 32'h00BBAAAA, 32'h00BBBB00);
    add("t3_disjoint", wr(9, 4'h1, 32'h11111111), wr(9, 4'h8, 32'h22222222), 1, 32'h00BBAAAA, 0, 1, 32'h00BBAAAA, 0, 0, 32'h00BBAA11, 32'h22BBAAAA);
    add("t3_rd2",      idle(),                    rd(9),                     0, 32'h00BBAAAA, 0, 1, 32'h22BBAA11, 0, 0, 32'h00BBAA11, 32'h22BBAA11);
    add("t4_xport",    rd(3),                     wr(3, 4'hF, 32'h00000005), 1, 32'h00000000, 0, 1, 32'h00000000, 0, 0, 32'h00000000, 32'h00000005);
    add("t4_rd",       rd(3),                     idle(),                    1, 32'h00000005, 0, 0, 32'h00000000, 0, 0, 32'h00000005, 32'h00000005);
    add("rr_same",     rd(5),                     rd(5),                     1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    add("t5_wr_oob",   wr(250, 4'hF, 32'hCAFEF00D), idle(),                  1, 32'h00000000, 1, 0, 32'hDEADBEEF, 0, 0, 32'h00000000, 32'hDEADBEEF);
    add("t5_rd_oob",   rd(250),                   idle(),                    1, 32'h00000000, 1, 0, 32'hDEADBEEF, 0, 0, 32'h00000000, 32'hDEADBEEF);
    add("edge_wr199",  wr(199, 4'hF, 32'h0000C0DE), idle(),                  1, 32'h00000000, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0000C0DE, 32'hDEADBEEF);
    add("edge_rd199",  rd(199),                   idle(),                    1, 32'h0000C0DE, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0000C0DE, 32'hDEADBEEF);
    add("edge_200",    rd(200),                   wr(200, 4'hF, 32'h12345678), 1, 32'h00000000, 1, 1, 32'h00000000, 1, 0, 32'h00000000, 32'h00000000);
    add("rd199_b",     idle(),                    rd(199),                   0, 32'h00000000, 0, 1, 32'h0000C0DE, 0, 0, 32'h00000000, 32'h0000C0DE);
    add("idle",        idle(),                    idle(),                    0, 32'h00000000, 0, 0, 32'h0000C0DE, 0, 0, 32'h00000000, 32'h0000C0DE);

    drive(idle(), idle());
    drive_l3(idle());
    if_l3.b_en = 1'b0; if_l3.b_we = 1'b0; if_l3.b_be = 4'h0; if_l3.b_addr = 8'h0; if_l3.b_wdata = 32'h0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;

    // ---- preload known contents, then leave nonzero read data on the outputs ----
    foreach (init_addrs[i]) begin
      drive(wr(init_addrs[i], 4'hF, 32'h0), idle());
      @(negedge clk);
    end
    drive(wr(11, 4'hF, 32'hFFFFFFFF), idle());
    @(negedge clk);
    drive(rd(11), rd(11));
    @(negedge clk);
    drive(idle(), idle());
    for (int i = 0; i < 4; i++) begin
      drive_l3(wr(8'(20 + i), 4'hF, 32'h100 + i));
      @(negedge clk);
    end
    drive_l3(rd(23));
    @(negedge clk);
    drive_l3(idle());
    repeat (4) @(negedge clk);
    check("pre_reset.a_rdata", if_rf.a_rdata, 32'hFFFFFFFF);
    check("pre_reset.l3_rdata", if_l3.a_rdata, 32'h00000103);

    // ---- reset state ----
    rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    check("rst.a_rdata",   if_rf.a_rdata, 32'h0);
    check("rst.b_rdata",   if_rf.b_rdata, 32'h0);
    check("rst.a_rvalid",  32'(if_rf.a_rvalid), 32'h0);
    check("rst.b_rvalid",  32'(if_rf.b_rvalid), 32'h0);
    check("rst.a_err",     32'(if_rf.a_err), 32'h0);
    check("rst.b_err",     32'(if_rf.b_err), 32'h0);
    check("rst.collision", 32'(if_rf.collision), 32'h0);
    check("rst.wf_a_rdata", if_wf.a_rdata, 32'h0);
    check("rst.l3_rdata",  if_l3.a_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;

    // ---- table-driven vectors, back-to-back ----
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b);
      @(negedge clk);
      check($sformatf("%s.a_rvalid", vecs[i].name), 32'(if_rf.a_rvalid), 32'(vecs[i].xav));
      check($sformatf("%s.a_rdata", vecs[i].name), if_rf.a_rdata, vecs[i].xad);
      check($sformatf("%s.a_err", vecs[i].name), 32'(if_rf.a_err), 32'(vecs[i].xae));
      check($sformatf("%s.b_rvalid", vecs[i].name), 32'(if_rf.b_rvalid), 32'(vecs[i].xbv));
      check($sformatf("%s.b_rdata", vecs[i].name), if_rf.b_rdata, vecs[i].xbd);
      check($sformatf("%s.b_err", vecs[i].name), 32'(if_rf.b_err), 32'(vecs[i].xbe));
      check($sformatf("%s.collision", vecs[i].name), 32'(if_rf.collision), 32'(vecs[i].xcoll));
      check($sformatf("%s.wf_a_rdata", vecs[i].name), if_wf.a_rdata, vecs[i].xawf);
      check($sformatf("%s.wf_b_rdata", vecs[i].name), if_wf.b_rdata, vecs[i].xbwf);
    end
    drive(idle(), idle());

    // ---- latency 3: single read pulse timing ----
    drive_l3(rd(21));
    @(negedge clk);
    drive_l3(idle());
    @(negedge clk);
    check("l3_lat.early_rvalid", 32'(if_l3.a_rvalid), 32'h0);
    @(negedge clk);
    check("l3_lat.rvalid", 32'(if_l3.a_rvalid), 32'h1);
    check("l3_lat.rdata", if_l3.a_rdata, 32'h00000101);

    // ---- latency 3: four consecutive reads, reset pulsed after the second ----
    drive_l3(rd(20));
    @(negedge clk);
    check("l3_rst.n2_rvalid", 32'(if_l3.a_rvalid), 32'h0);
    drive_l3(rd(21));
    @(negedge clk);
    rst2_n = 1'b0;
    drive_l3(rd(22));
    #1;
    check("l3_rst.in_rst_rvalid", 32'(if_l3.a_rvalid), 32'h0);
    check("l3_rst.in_rst_rdata", if_l3.a_rdata, 32'h0);
    #1;
    rst2_n = 1'b1;
    @(negedge clk);
    check("l3_rst.drop1_rvalid", 32'(if_l3.a_rvalid), 32'h0);
    drive_l3(rd(23));
    @(negedge clk);
    check("l3_rst.drop2_rvalid", 32'(if_l3.a_rvalid), 32'h0);
    check("l3_rst.drop2_rdata", if_l3.a_rdata, 32'h0);
    drive_l3(idle());
    @(negedge clk);
    check("l3_rst.rd3_rvalid", 32'(if_l3.a_rvalid), 32'h1);
    check("l3_rst.rd3_rdata", if_l3.a_rdata, 32'h00000102);
    check("l3_rst.rd3_err", 32'(if_l3.a_err), 32'h0);
    @(negedge clk);
    check("l3_rst.rd4_rvalid", 32'(if_l3.a_rvalid), 32'h1);
    check("l3_rst.rd4_rdata", if_l3.a_rdata, 32'h00000103);
    @(negedge clk);
    check("l3_rst.after_rvalid", 32'(if_l3.a_rvalid), 32'h0);
    check("l3_rst.after_rdata", if_l3.a_rdata, 32'h00000103);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
